// File: rtl/hex_entry_pkg.sv
// Shared types and helpers for the hex operand entry block.
// Imported by the key debouncer and the entry top level.
package hex_entry_pkg;

    typedef enum logic {
        ENTRY,
        SEND
    } entry_state_e;

    localparam int DIGIT_W = 4;

    function automatic logic is_pressed(logic lvl, logic active_low);
        return active_low ? ~lvl : lvl;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer, debounce counter and press-edge detector
// for a single raw pushbutton.
module key_debounce
    import hex_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_raw,
    output logic o_level,
    output logic o_press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic RELEASED_RAW = KEY_ACTIVE_LOW;

    logic          sync1;
    logic          sync2;
    logic          synced;
    logic [CW-1:0] cnt;

    assign synced = is_pressed(sync2, KEY_ACTIVE_LOW);

    // o_level is in the pressed domain: 1 means the key is held down
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1         <= RELEASED_RAW;
            sync2         <= RELEASED_RAW;
            cnt           <= '0;
            o_level       <= 1'b0;
            o_press_pulse <= 1'b0;
        end else begin
            sync1         <= i_key_raw;
            sync2         <= sync1;
            o_press_pulse <= 1'b0;
            if (synced == o_level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt           <= '0;
                o_level       <= synced;
                o_press_pulse <= synced;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/hex_entry.sv
// Hex operand entry: debounced keys shift switch nibbles into a
// register that is then offered downstream over valid/ready.
module hex_entry
    import hex_entry_pkg::*;
#(
    parameter int SIZE_DATA       = 32,
    parameter int SIZE_DIGIT      = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [SIZE_DIGIT-1:0] i_sw_digit,
    input  logic                  i_key_push,
    input  logic                  i_key_clear,
    input  logic                  i_key_send,
    input  logic                  i_ready,
    output logic [SIZE_DATA-1:0]  o_data,
    output logic                  o_valid,
    output logic [3:0]            o_digit_cnt,
    output logic                  o_full
);

    localparam logic [3:0] MAX_DIGITS = 4'(SIZE_DATA / DIGIT_W);

    entry_state_e          state;
    logic [SIZE_DIGIT-1:0] sw_meta;
    logic [SIZE_DIGIT-1:0] sw_sync;
    logic                  push_p;
    logic                  clear_p;
    logic                  send_p;
    logic [2:0]            unused_level;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_push (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_key_raw    (i_key_push),
        .o_level      (unused_level[0]),
        .o_press_pulse(push_p)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_clear (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_key_raw    (i_key_clear),
        .o_level      (unused_level[1]),
        .o_press_pulse(clear_p)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_send (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_key_raw    (i_key_send),
        .o_level      (unused_level[2]),
        .o_press_pulse(send_p)
    );

    assign o_full = (o_digit_cnt == MAX_DIGITS);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= i_sw_digit;
            sw_sync <= sw_meta;
        end
    end

    // Clear beats send beats push; SEND ignores all key events
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ENTRY;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_digit_cnt <= '0;
        end else begin
            unique case (state)
                ENTRY: begin
                    if (clear_p) begin
                        o_data      <= '0;
                        o_digit_cnt <= '0;
                    end else if (send_p) begin
                        state   <= SEND;
                        o_valid <= 1'b1;
                    end else if (push_p && !o_full) begin
                        o_data      <= {o_data[SIZE_DATA-DIGIT_W-1:0], sw_sync};
                        o_digit_cnt <= o_digit_cnt + 4'd1;
                    end
                end
                SEND: begin
                    if (i_ready) begin
                        state       <= ENTRY;
                        o_valid     <= 1'b0;
                        o_data      <= '0;
                        o_digit_cnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_entry.sv
// Self-checking bench for hex_entry with a short debounce window.
// A cycle model predicts outputs from the raw key history.
module tb_hex_entry;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  sw = 4'h0;
    logic        key_push = 1'b1;
    logic        key_clear = 1'b1;
    logic        key_send = 1'b1;
    logic        ready = 1'b0;
    logic [31:0] o_data;
    logic        o_valid;
    logic [3:0]  o_digit_cnt;
    logic        o_full;

    int n_checks = 0;
    int n_fail = 0;
    bit run_cmp = 1'b0;

    always #5 clk = ~clk;

    hex_entry #(
        .SIZE_DATA      (32),
        .SIZE_DIGIT     (4),
        .DEBOUNCE_CYCLES(D),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_sw_digit (sw),
        .i_key_push (key_push),
        .i_key_clear(key_clear),
        .i_key_send (key_send),
        .i_ready    (ready),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_digit_cnt(o_digit_cnt),
        .o_full     (o_full)
    );

    // hist bit i = key pressed as sampled i edges ago; swh[i] likewise
    typedef struct packed {
        logic [31:0]     data;
        logic [3:0]      cnt;
        logic            valid;
        logic [2:0]      lvl;
        logic [2:0]      pend;
        logic [2:0][7:0] hist;
        logic [2:0][3:0] swh;
    } model_t;

    model_t m = '0;

    function automatic model_t step(model_t s, logic [2:0] pr,
                                    logic [3:0] d, logic rdy);
        model_t n = s;
        logic all_diff;
        for (int k = 0; k < 3; k++)
            n.hist[k] = {s.hist[k][6:0], pr[k]};
        n.swh = {s.swh[1], s.swh[0], d};
        if (s.valid) begin
            if (rdy) begin
                n.valid = 1'b0;
                n.data  = '0;
                n.cnt   = '0;
            end
        end else if (s.pend[1]) begin
            n.data = '0;
            n.cnt  = '0;
        end else if (s.pend[2]) begin
            n.valid = 1'b1;
        end else if (s.pend[0] && s.cnt < 4'd8) begin
            n.data = {s.data[27:0], n.swh[2]};
            n.cnt  = s.cnt + 4'd1;
        end
        for (int k = 0; k < 3; k++) begin
            all_diff = 1'b1;
            for (int i = 2; i <= D + 1; i++)
                if (n.hist[k][i] == s.lvl[k]) all_diff = 1'b0;
            n.pend[k] = 1'b0;
            if (all_diff) begin
                n.lvl[k]  = ~s.lvl[k];
                n.pend[k] = ~s.lvl[k];
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else m <= step(m, ~{key_send, key_clear, key_push}, sw, ready);
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            check("model_data", o_data, m.data);
            check("model_cnt", 32'(o_digit_cnt), 32'(m.cnt));
            check("model_valid", 32'(o_valid), 32'(m.valid));
            check("model_full", 32'(o_full), 32'(m.cnt == 4'd8));
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_key(int k, logic v);
        case (k)
            0: key_push = v;
            1: key_clear = v;
            default: key_send = v;
        endcase
    endtask

    task automatic press(int k);
        set_key(k, 1'b0);
        cyc(D + 4);
        set_key(k, 1'b1);
        cyc(D + 4);
    endtask

    task automatic push_digit(logic [3:0] d);
        sw = d;
        press(0);
    endtask

    task automatic wait_valid(int budget);
        int i = 0;
        while (!o_valid && i < budget) begin
            cyc(1);
            i++;
        end
        check("valid_timeout", 32'(o_valid), 32'd1);
    endtask

    logic [3:0] pi_digits[8] = '{4'h3, 4'hF, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] pi2_digits[8] = '{4'h4, 4'h0, 4'h4, 4'h9, 4'h0, 4'hF, 4'hD, 4'hB};

    initial begin
        int vc;
        #1 rst_n = 1'b0;
        #3;
        check("reset_data", o_data, 32'h0);
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_cnt", 32'(o_digit_cnt), 32'd0);
        check("reset_full", 32'(o_full), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        run_cmp = 1'b1;
        cyc(2);

        // 1: fill all eight digits, then one more push is ignored
        foreach (pi_digits[i]) push_digit(pi_digits[i]);
        check("fill_data", o_data, 32'h3F80_0000);
        check("fill_cnt", 32'(o_digit_cnt), 32'd8);
        check("fill_full", 32'(o_full), 32'd1);
        push_digit(4'hA);
        check("overfill_data", o_data, 32'h3F80_0000);
        check("overfill_cnt", 32'(o_digit_cnt), 32'd8);

        // 2: bouncing push key yields exactly one event, 7 cycles after settling
        press(1);
        sw = 4'h5;
        cyc(3);
        for (int i = 0; i < 10; i++) begin
            key_push = i[0];
            cyc(2);
        end
        key_push = 1'b0;
        cyc(6);
        check("bounce_early", 32'(o_digit_cnt), 32'd0);
        cyc(1);
        check("bounce_event", 32'(o_digit_cnt), 32'd1);
        cyc(20);
        key_push = 1'b1;
        cyc(D + 4);
        check("bounce_once", 32'(o_digit_cnt), 32'd1);
        check("bounce_data", o_data, 32'h0000_0005);

        // 3: send with ready arriving late
        press(1);
        foreach (pi2_digits[i]) push_digit(pi2_digits[i]);
        check("pi_data", o_data, 32'h4049_0FDB);
        key_send = 1'b0;
        wait_valid(40);
        for (int i = 0; i < 5; i++) begin
            check("late_hold_valid", 32'(o_valid), 32'd1);
            check("late_hold_data", o_data, 32'h4049_0FDB);
            cyc(1);
        end
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
        check("late_done_valid", 32'(o_valid), 32'd0);
        check("late_done_data", o_data, 32'h0);
        check("late_done_cnt", 32'(o_digit_cnt), 32'd0);
        key_send = 1'b1;
        cyc(D + 4);

        // 4: ready already high gives a one-cycle offer
        push_digit(4'h7);
        ready = 1'b1;
        key_send = 1'b0;
        vc = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (o_valid) vc++;
        end
        check("early_valid_cycles", 32'(vc), 32'd1);
        key_send = 1'b1;
        ready = 1'b0;
        cyc(D + 4);
        push_digit(4'h1);
        press(2);
        check("send_held_valid", 32'(o_valid), 32'd1);
        push_digit(4'h9);
        press(1);
        check("send_frozen_data", o_data, 32'h0000_0001);
        check("send_frozen_valid", 32'(o_valid), 32'd1);
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
        check("send_drop_valid", 32'(o_valid), 32'd0);

        // 5: clear and push in the same cycle, clear wins
        push_digit(4'hA);
        push_digit(4'hB);
        check("prio_pre_data", o_data, 32'h0000_00AB);
        key_push = 1'b0;
        key_clear = 1'b0;
        cyc(D + 4);
        key_push = 1'b1;
        key_clear = 1'b1;
        cyc(D + 4);
        check("prio_data", o_data, 32'h0);
        check("prio_cnt", 32'(o_digit_cnt), 32'd0);

        // 6: asynchronous reset while an operand is offered
        push_digit(4'hC);
        press(2);
        check("rst_pre_valid", 32'(o_valid), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(o_valid), 32'd0);
        check("async_rst_data", o_data, 32'h0);
        check("async_rst_cnt", 32'(o_digit_cnt), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(4);
        check("post_rst_valid", 32'(o_valid), 32'd0);

        run_cmp = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
